// File: rtl/fabric_fle_pkg.sv
// Shared types and chain-layout helpers for the fracturable logic element.
// Chain layout: mask | frac | carry | dsel[NUM_FF] | osel[NUM_FF], LSB first.
package fabric_fle_pkg;

    typedef enum logic [1:0] {
        ST_UNCONF = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } fle_state_e;

    function automatic int chain_len(input int k, input int n);
        return (1 << k) + 2 + 2 * n;
    endfunction

    function automatic int frac_off(input int k);
        return (1 << k);
    endfunction

    function automatic int carry_off(input int k);
        return (1 << k) + 1;
    endfunction

    function automatic int dsel_off(input int k);
        return (1 << k) + 2;
    endfunction

    function automatic int osel_off(input int k, input int n);
        return (1 << k) + 2 + n;
    endfunction

endpackage

// File: rtl/fabric_fle_lut.sv
// Combinational K-input LUT: whole, fractured into two (K-1)-LUTs, or carry cell.
module fabric_fle_lut
    import fabric_fle_pkg::*;
#(
    parameter int LUT_K = 4
) (
    input  logic [(1<<LUT_K)-1:0] mask_i,
    input  logic                  frac_i,
    input  logic                  carry_i,
    input  logic [LUT_K-1:0]      lut_in_i,
    input  logic                  cin_i,
    output logic                  lut_o0_o,
    output logic                  lut_o1_o,
    output logic                  cout_o
);

    localparam int HALF = 1 << (LUT_K - 1);

    logic [HALF-1:0] mask_lo;
    logic [HALF-1:0] mask_hi;
    logic            lo;
    logic            hi;
    logic            full;

    assign mask_lo = mask_i[HALF-1:0];
    assign mask_hi = mask_i[2*HALF-1:HALF];
    assign lo      = mask_lo[lut_in_i[LUT_K-2:0]];
    assign hi      = mask_hi[lut_in_i[LUT_K-2:0]];
    assign full    = lut_in_i[LUT_K-1] ? hi : lo;

    // Carry mode takes priority over fracture.
    always_comb begin
        lut_o0_o = full;
        lut_o1_o = full;
        cout_o   = 1'b0;
        if (carry_i) begin
            lut_o0_o = lo ^ cin_i;
            lut_o1_o = lo ^ cin_i;
            cout_o   = lo ? cin_i : hi;
        end else if (frac_i) begin
            lut_o0_o = lo;
            lut_o1_o = hi;
        end
    end

endmodule

// File: rtl/fabric_fle_param.sv
// Fracturable logic element: serial config chain, load-check FSM, scannable FFs, output muxes.
// Optional FABRIC_FLE_READBACK_EN adds ccff_rotate to recirculate the chain through ccff_tail.
//
// state     | meaning
// UNCONF    | out of reset, no configuration loaded yet
// LOAD      | chain shifting, shifts being counted
// ACTIVE    | last load had exactly CHAIN_LEN bits; element live
// ERROR     | last load had the wrong bit count; outputs held at 0
module fabric_fle_param
    import fabric_fle_pkg::*;
#(
    parameter int LUT_K  = 4,
    parameter int NUM_FF = 2
) (
    input  logic              fabric_clk,
    input  logic              fabric_reset,
    input  logic              config_enable,
    input  logic              Test_en,
    input  logic [LUT_K-1:0]  fabric_in,
    input  logic              fabric_cin,
    input  logic              fabric_sc_in,
    input  logic              fabric_ce,
    input  logic              ccff_head,
`ifdef FABRIC_FLE_READBACK_EN
    input  logic              ccff_rotate,
`endif
    output logic [NUM_FF-1:0] fabric_out,
    output logic              fabric_cout,
    output logic              fabric_sc_out,
    output logic              ccff_tail,
    output logic              config_done,
    output logic              cfg_err
);

    localparam int CHAIN_LEN = chain_len(LUT_K, NUM_FF);
    localparam int MASK_W    = 1 << LUT_K;
    localparam int FRAC_OFF  = frac_off(LUT_K);
    localparam int CARRY_OFF = carry_off(LUT_K);
    localparam int DSEL_OFF  = dsel_off(LUT_K);
    localparam int OSEL_OFF  = osel_off(LUT_K, NUM_FF);
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

    logic [CHAIN_LEN-1:0] chain_q, chain_d;
    logic [NUM_FF-1:0]    ff_q, ff_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    fle_state_e           state_q, state_d;

    logic [MASK_W-1:0] mask;
    logic              frac;
    logic              carry;
    logic [NUM_FF-1:0] dsel;
    logic [NUM_FF-1:0] osel;
    logic              feed;
    logic              active;
    logic              ff_upd;
    logic              lut_o0, lut_o1, lut_cout;
    logic [1:0]        lut_o;
    logic [NUM_FF-1:0] scan_src;
    logic [NUM_FF-1:0] chain_src;

    assign mask  = chain_q[MASK_W-1:0];
    assign frac  = chain_q[FRAC_OFF];
    assign carry = chain_q[CARRY_OFF];
    assign dsel  = chain_q[DSEL_OFF +: NUM_FF];
    assign osel  = chain_q[OSEL_OFF +: NUM_FF];

`ifdef FABRIC_FLE_READBACK_EN
    assign feed = ccff_rotate ? chain_q[CHAIN_LEN-1] : ccff_head;
`else
    assign feed = ccff_head;
`endif

    always_comb begin
        chain_d = chain_q;
        if (config_enable) begin
            chain_d = {chain_q[CHAIN_LEN-2:0], feed};
        end
    end

    // Counter is loaded with 1 on entry because the entering cycle is itself a shift.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (config_enable) begin
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = (cnt_q == CNT_FULL) ? ST_ACTIVE : ST_ERROR;
                end
            end
            ST_UNCONF, ST_ACTIVE, ST_ERROR: begin
                if (config_enable) begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: state_d = ST_UNCONF;
        endcase
    end

    fabric_fle_lut #(
        .LUT_K (LUT_K)
    ) u_lut (
        .mask_i   (mask),
        .frac_i   (frac),
        .carry_i  (carry),
        .lut_in_i (fabric_in),
        .cin_i    (fabric_cin),
        .lut_o0_o (lut_o0),
        .lut_o1_o (lut_o1),
        .cout_o   (lut_cout)
    );

    assign lut_o  = {lut_o1, lut_o0};
    assign active = (state_q == ST_ACTIVE);
    // A rising config_enable blocks the user update in the same cycle.
    assign ff_upd = active && !config_enable && (fabric_ce || Test_en);

    assign scan_src  = NUM_FF'({ff_q, fabric_sc_in});
    assign chain_src = NUM_FF'({ff_q, lut_o1});

    always_comb begin
        ff_d = ff_q;
        if (ff_upd) begin
            for (int i = 0; i < NUM_FF; i++) begin
                if (Test_en) begin
                    ff_d[i] = scan_src[i];
                end else if (dsel[i]) begin
                    ff_d[i] = chain_src[i];
                end else begin
                    ff_d[i] = lut_o[i % 2];
                end
            end
        end
    end

    always_comb begin
        fabric_out = '0;
        if (active) begin
            for (int i = 0; i < NUM_FF; i++) begin
                fabric_out[i] = osel[i] ? ff_q[i] : lut_o[i % 2];
            end
        end
    end

    assign fabric_cout   = active & lut_cout;
    assign fabric_sc_out = ff_q[NUM_FF-1];
    assign ccff_tail     = chain_q[CHAIN_LEN-1];
    assign config_done   = active;
    assign cfg_err       = (state_q == ST_ERROR);

    always_ff @(posedge fabric_clk or negedge fabric_reset) begin
        if (!fabric_reset) begin
            chain_q <= '0;
            ff_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_UNCONF;
        end else begin
            chain_q <= chain_d;
            ff_q    <= ff_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule
